// File: rtl/ydemux2_stage_if.sv
// ydemux2_stage_if: input handshake, two output channels and accept counters of ydemux2_stage.
interface ydemux2_stage_if #(parameter int WIDTH = 32);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;
    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;
    logic [7:0]       cnt0;
    logic [7:0]       cnt1;
    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );
    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );
endinterface

// File: rtl/ydemux2_stage.sv
// ydemux2_stage: registered 1-to-2 demux into two single-entry slots; counters built only with YDEMUX2_STAGE_CNT_EN.
module ydemux2_stage #(
    parameter int WIDTH = 32
) (
    input logic             clk,
    input logic             reset,
    ydemux2_stage_if.slave  bus
);
    logic             r_v0, r_v1;
    logic [WIDTH-1:0] r_d0, r_d1;
    logic             w_drain0, w_drain1, w_ready, w_acc0, w_acc1;

    assign w_drain0 = r_v0 & bus.out0_ready;
    assign w_drain1 = r_v1 & bus.out1_ready;
    // a full slot blocks the input even if the other slot is free
    assign w_ready  = bus.in_sel ? (~r_v1 | w_drain1) : (~r_v0 | w_drain0);
    assign w_acc0   = bus.in_valid & w_ready & ~bus.in_sel;
    assign w_acc1   = bus.in_valid & w_ready & bus.in_sel;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_v0 <= 1'b0;
            r_v1 <= 1'b0;
            r_d0 <= '0;
            r_d1 <= '0;
        end else begin
            r_v0 <= w_acc0 | (r_v0 & ~w_drain0);
            r_v1 <= w_acc1 | (r_v1 & ~w_drain1);
            if (w_acc0) r_d0 <= bus.in_data;
            if (w_acc1) r_d1 <= bus.in_data;
        end
    end

`ifdef YDEMUX2_STAGE_CNT_EN
    logic [7:0] r_cnt0, r_cnt1;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt0 <= 8'd0;
            r_cnt1 <= 8'd0;
        end else begin
            if (w_acc0) r_cnt0 <= r_cnt0 + 8'd1;
            if (w_acc1) r_cnt1 <= r_cnt1 + 8'd1;
        end
    end
    assign bus.cnt0 = r_cnt0;
    assign bus.cnt1 = r_cnt1;
`else
    assign bus.cnt0 = 8'd0;
    assign bus.cnt1 = 8'd0;
`endif

    assign bus.in_ready   = w_ready;
    assign bus.out0_valid = r_v0;
    assign bus.out0_data  = r_d0;
    assign bus.out1_valid = r_v1;
    assign bus.out1_data  = r_d1;
endmodule
